// File: rtl/vga_pkg.sv
// Shared display geometry, reset position, FSM state type and the per-axis step function
// used by the ball motion controller.
package vga_pkg;

    localparam int unsigned H_ACT_DEF   = 640;
    localparam int unsigned V_ACT_DEF   = 480;
    localparam int unsigned BALL_SZ_DEF = 16;
    localparam int unsigned POS_W       = 10;

    localparam logic [POS_W-1:0] RST_X = POS_W'((H_ACT_DEF - BALL_SZ_DEF) / 2);
    localparam logic [POS_W-1:0] RST_Y = POS_W'((V_ACT_DEF - BALL_SZ_DEF) / 2);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        MOVE_X,
        MOVE_Y,
        COMMIT
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic             dir;   // 1 = moving toward lim
        logic             hit;   // wall reached this frame (auto mode only)
    } axis_t;

    // One frame of motion on a single axis; clamps to 0..lim in both modes.
    function automatic axis_t axis_next(
        input logic [POS_W-1:0] pos,
        input logic             dir,
        input logic [3:0]       step,
        input logic             man,
        input logic             btn_inc,
        input logic             btn_dec,
        input logic [POS_W-1:0] lim
    );
        axis_t          r;
        logic [POS_W:0] sum;
        logic           at_hi;
        logic           at_lo;
        r.pos = pos;
        r.dir = dir;
        r.hit = 1'b0;
        sum   = {1'b0, pos} + (POS_W+1)'(step);
        at_hi = (sum >= {1'b0, lim});
        at_lo = (pos <= POS_W'(step));
        if (man) begin
            if (btn_inc && !btn_dec) begin
                r.pos = at_hi ? lim : sum[POS_W-1:0];
            end else if (btn_dec && !btn_inc) begin
                r.pos = at_lo ? '0 : pos - POS_W'(step);
            end
        end else if (dir) begin
            if (at_hi) begin
                r.pos = lim;
                r.dir = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.pos = sum[POS_W-1:0];
            end
        end else begin
            if (at_lo) begin
                r.pos = '0;
                r.dir = 1'b1;
                r.hit = 1'b1;
            end else begin
                r.pos = pos - POS_W'(step);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the four asynchronous push buttons.
module btn_sync
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous sprite position controller (auto bounce or button steering).
// Define BALL_BOUNCE_CNT_EN to build the wall-hit counter; otherwise bounce_cnt is tied to 0.
module ball_motion_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned H_ACT   = H_ACT_DEF,
    parameter int unsigned V_ACT   = V_ACT_DEF,
    parameter int unsigned BALL_SZ = BALL_SZ_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        manual,
    input  logic [2:0]  speed,
    input  logic        frame_start,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic        pos_valid,
    output logic [15:0] bounce_cnt,
    output logic        overrun
);

    localparam logic [POS_W-1:0] X_MAX = POS_W'(H_ACT - BALL_SZ);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_ACT - BALL_SZ);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       btn;        // {up, down, left, right}
    logic [3:0]       step_q;
    logic             man_q;
    logic [3:0]       step_c;
    logic             man_c;
    logic [POS_W-1:0] sh_x;
    logic [POS_W-1:0] sh_y;
    logic             dir_x;
    logic             dir_y;
    logic             fs_lost_c;
    axis_t            nx;
    axis_t            ny;

    btn_sync u_btn_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({up, down, left, right}),
        .q       (btn)
    );

    // Next state, sampled-or-held mode, and per-axis step results.
    always_comb begin
        state_nxt = state;
        step_c    = step_q;
        man_c     = man_q;
        fs_lost_c = frame_start && (state != WAIT_FRAME);
        case (state)
            IDLE:       if (run) state_nxt = WAIT_FRAME;
            WAIT_FRAME: begin
                if (!run)             state_nxt = IDLE;
                else if (frame_start) state_nxt = MOVE_X;
            end
            MOVE_X: begin
                state_nxt = MOVE_Y;
                step_c    = 4'(speed) + 4'd1;
                man_c     = manual;
            end
            MOVE_Y:     state_nxt = COMMIT;
            COMMIT:     state_nxt = run ? WAIT_FRAME : IDLE;
            default:    state_nxt = IDLE;
        endcase
        nx = axis_next(ball_x, dir_x, step_c, man_c, btn[0], btn[1], X_MAX);
        ny = axis_next(ball_y, dir_y, step_c, man_c, btn[2], btn[3], Y_MAX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Shadow positions build up over MOVE_X/MOVE_Y; the visible pair changes only at COMMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ball_x    <= RST_X;
            ball_y    <= RST_Y;
            sh_x      <= RST_X;
            sh_y      <= RST_Y;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            step_q    <= 4'd1;
            man_q     <= 1'b0;
            pos_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pos_valid <= (state == COMMIT);
            if (fs_lost_c) overrun <= 1'b1;
            case (state)
                MOVE_X: begin
                    step_q <= step_c;
                    man_q  <= man_c;
                    sh_x   <= nx.pos;
                    dir_x  <= nx.dir;
                end
                MOVE_Y: begin
                    sh_y  <= ny.pos;
                    dir_y <= ny.dir;
                end
                COMMIT: begin
                    ball_x <= sh_x;
                    ball_y <= sh_y;
                end
                default: ;
            endcase
        end
    end

`ifdef BALL_BOUNCE_CNT_EN
    logic        hit_x;
    logic        hit_y;
    logic [15:0] bounce_q;

    // Hits are held until COMMIT so the count moves together with the position pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_x    <= 1'b0;
            hit_y    <= 1'b0;
            bounce_q <= '0;
        end else begin
            case (state)
                MOVE_X:  hit_x <= nx.hit;
                MOVE_Y:  hit_y <= ny.hit;
                COMMIT:  bounce_q <= bounce_q + 16'(hit_x) + 16'(hit_y);
                default: ;
            endcase
        end
    end

    assign bounce_cnt = bounce_q;
`else
    logic unused_hits;
    assign unused_hits = nx.hit | ny.hit;
    assign bounce_cnt  = '0;
`endif

endmodule

// File: doc/ball_motion_ctrl.md
BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

Interface
REQ-001 SHALL have parameter H_ACT, default 640, meaning visible width in pixels.
REQ-002 SHALL have parameter V_ACT, default 480, meaning visible height in lines.
REQ-003 SHALL have parameter BALL_SZ, default 16, meaning square sprite edge in pixels.
REQ-004 SHALL have ports as follows, one per line:
  clk  in  1  system clock, 100 MHz.
  reset_n  in  1  asynchronous active-low reset.
  run  in  1  motion enable, level.
  manual  in  1  1 = button steering, 0 = autonomous bounce.
  speed  in  3  step per frame, minus one (step = speed+1, 1..8 px).
  frame_start  in  1  one-clk strobe at start of vertical blank.
  up, down, left, right  in  1 each  raw push buttons, asynchronous.
  ball_x  out  10  committed sprite left column.
  ball_y  out  10  committed sprite top line.
  pos_valid  out  1  one-clk pulse when ball_x/ball_y update.
  bounce_cnt  out  16  wall-hit count, for LEDs.
  overrun  out  1  sticky: frame_start arrived while busy.

Function
REQ-005 SHALL hold limits X_MAX = H_ACT-BALL_SZ (624) and Y_MAX = V_ACT-BALL_SZ (464); committed positions SHALL never exceed them.
REQ-006 SHALL implement FSM states IDLE, WAIT_FRAME, MOVE_X, MOVE_Y, COMMIT.
REQ-007 IDLE -> WAIT_FRAME when run=1; WAIT_FRAME -> IDLE when run=0; WAIT_FRAME -> MOVE_X when frame_start=1.
REQ-008 MOVE_X -> MOVE_Y -> COMMIT unconditionally, one clk each; COMMIT -> WAIT_FRAME if run=1, else IDLE (run drop mid-update completes the update).
REQ-009 MOVE_X SHALL compute shadow x; MOVE_Y shadow y; COMMIT SHALL copy shadows to ball_x/ball_y, visible after the COMMIT edge: 4 clk after the edge sampling frame_start; pos_valid SHALL be high for exactly that one following clk.
REQ-010 ball_x/ball_y SHALL change only at COMMIT; display never sees a half-updated pair.
REQ-011 Auto mode, axis moving +: if pos+step >= MAX then pos=MAX, direction flips to -, bounce_cnt+1; else pos+=step.
REQ-012 Auto mode, axis moving -: if pos <= step then pos=0, direction flips to +, bounce_cnt+1; else pos-=step.
REQ-013 Corner hit (both axes clamp same frame) SHALL add 2 to bounce_cnt; bounce_cnt SHALL wrap 65535 -> 0.
REQ-014 Manual mode: held button moves axis by step toward it, clamped at 0/MAX, no direction flip, no bounce count; opposing buttons both held or none -> axis unchanged.
REQ-015 Buttons SHALL pass a 2-flop synchronizer before use; level sampled in MOVE_X/MOVE_Y.
REQ-016 speed and manual SHALL be sampled in MOVE_X and held for the update.
REQ-017 frame_start outside WAIT_FRAME SHALL be ignored and set overrun; overrun clears only on reset.

Reset
REQ-018 reset_n low SHALL immediately force: state IDLE, ball_x=312, ball_y=232, both directions +, pos_valid=0, bounce_cnt=0, overrun=0, synchronizer flops 0.
REQ-019 Reset asserted mid-update SHALL abort it; no COMMIT occurs.

Configuration
REQ-020 With macro BALL_BOUNCE_CNT_EN defined, bounce_cnt SHALL behave per REQ-011..013.
REQ-021 Without BALL_BOUNCE_CNT_EN, bounce_cnt SHALL be constant 0 and its counter register SHALL not exist; all other behaviour unchanged.

Structure
REQ-022 Package vga_pkg SHALL hold H_ACT/V_ACT/BALL_SZ defaults, reset position constants, and the FSM state enum typedef.
REQ-023 One sub-module btn_sync SHALL implement the 4-bit 2-flop synchronizer.

Verification
REQ-024 Reset, run=1, manual=0, speed=0, one frame_start -> after 4 clk ball_x=313, ball_y=233, pos_valid one clk.
REQ-025 Auto, speed=7, ball_x=620 moving + -> next commit ball_x=624, x direction -, bounce_cnt=1; following frame ball_x=616.
REQ-026 Auto, ball_x=0 and ball_y=0 both moving -, speed=0 -> commit at 0/0, bounce_cnt+=2, next frame 1/1.
REQ-027 Manual, speed=3, left+right held and down held, ball_y=462 -> ball_x unchanged, ball_y=464 clamped, bounce_cnt unchanged.
REQ-028 frame_start pulsed in MOVE_Y -> overrun=1, exactly one commit; run dropped in MOVE_X -> commit completes, FSM in IDLE, later strobes ignored.
REQ-029 reset_n low during MOVE_Y -> outputs at reset values immediately, no pos_valid; build without BALL_BOUNCE_CNT_EN -> bounce_cnt=0 after walls hit.
